// File: rtl/sipo_deserializer.sv
// sipo_deserializer: rebuilds WIDTH-bit words from a Start-framed serial stream and presents them through a valid/ready handshake with a sticky overrun flag
//   in : Clk, Rst_n (sync, active-low), Serial_In, Shift_En, Start, Out_Ready, Clr_Ovr
//   out: Parallel_Out (last completed word), Out_Valid, Busy (partial word in progress), Overrun
module sipo_deserializer #(
  parameter int WIDTH = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Serial_In,
  input  logic             Shift_En,
  input  logic             Start,
  input  logic             Out_Ready,
  input  logic             Clr_Ovr,
  output logic [WIDTH-1:0] Parallel_Out,
  output logic             Out_Valid,
  output logic             Busy,
  output logic             Overrun
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d, pout_q, pout_d, base, nxt;
  logic [CW-1:0] cnt_q, cnt_d;
  logic valid_q, valid_d, ovr_q, ovr_d, accept, done;
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      pout_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      pout_q  <= pout_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end
  // Start discards the partial word, so the incoming bit shifts into an empty register
  always_comb begin
    accept  = Shift_En && (Start || state_q == SHIFT);
    base    = Start ? '0 : sreg_q;
    nxt     = MSB_FIRST ? {base[WIDTH-2:0], Serial_In} : {Serial_In, base[WIDTH-1:1]};
    done    = accept && !Start && cnt_q == CW'(WIDTH - 1);
    state_d = Start ? SHIFT : state_q;
    sreg_d  = accept ? nxt : base;
    cnt_d   = Start ? CW'(Shift_En) : done ? '0 : accept ? cnt_q + CW'(1) : cnt_q;
    pout_d  = done ? nxt : pout_q;
    valid_d = done | (valid_q & ~Out_Ready);
    ovr_d   = (done & valid_q & ~Out_Ready) | (ovr_q & ~Clr_Ovr);
  end
  assign Parallel_Out = pout_q;
  assign Out_Valid    = valid_q;
  assign Overrun      = ovr_q;
  assign Busy         = state_q == SHIFT && cnt_q != '0;
endmodule

// File: tb/tb_sipo_deserializer.sv
// tb_sipo_deserializer: directed and random stimulus against a frame-level reference model, MSB- and LSB-first instances in parallel
module tb_sipo_deserializer;
  localparam int W = 4;
  logic clk = 0, rst_n = 0, si = 0, se = 0, st = 0, rdy = 0, clr = 0;
  logic [W-1:0] po_m, po_l;
  logic vo_m, vo_l, bz_m, bz_l, ov_m, ov_l;
  int checks = 0, fails = 0;
  bit in_frame = 0;
  bit bits[$];
  logic [W-1:0] e_m = 0, e_l = 0;
  logic e_v = 0, e_o = 0;
  always #5 clk = ~clk;
  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_m (
    .Clk(clk), .Rst_n(rst_n), .Serial_In(si), .Shift_En(se), .Start(st), .Out_Ready(rdy), .Clr_Ovr(clr),
    .Parallel_Out(po_m), .Out_Valid(vo_m), .Busy(bz_m), .Overrun(ov_m));
  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_l (
    .Clk(clk), .Rst_n(rst_n), .Serial_In(si), .Shift_En(se), .Start(st), .Out_Ready(rdy), .Clr_Ovr(clr),
    .Parallel_Out(po_l), .Out_Valid(vo_l), .Busy(bz_l), .Overrun(ov_l));
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // Frame-level reference: collect received bits in a queue and pack a word once WIDTH have arrived
  task automatic model_step();
    bit done;
    logic [W-1:0] wm, wl;
    done = 0;
    wm = '0;
    wl = '0;
    if (!rst_n) begin
      in_frame = 0;
      bits.delete();
      e_m = '0;
      e_l = '0;
      e_v = 0;
      e_o = 0;
    end else begin
      if (st) begin
        in_frame = 1;
        bits.delete();
        if (se) bits.push_back(si);
      end else if (in_frame && se) begin
        bits.push_back(si);
        if (bits.size() == W) begin
          done = 1;
          for (int i = 0; i < W; i++) begin
            wm[W-1-i] = bits[i];
            wl[i] = bits[i];
          end
          bits.delete();
        end
      end
      if (done && e_v && !rdy) e_o = 1;
      else if (clr) e_o = 0;
      if (done) e_v = 1;
      else if (e_v && rdy) e_v = 0;
      if (done) begin
        e_m = wm;
        e_l = wl;
      end
    end
  endtask
  task automatic cyc(input logic r, input logic s, input logic e, input logic d, input logic y, input logic c);
    logic eb;
    rst_n = r; st = s; se = e; si = d; rdy = y; clr = c;
    @(posedge clk);
    model_step();
    #1;
    eb = in_frame && bits.size() != 0;
    chk("pout_msb", po_m, e_m);
    chk("pout_lsb", po_l, e_l);
    chk("valid_msb", W'(vo_m), W'(e_v));
    chk("valid_lsb", W'(vo_l), W'(e_v));
    chk("busy_msb", W'(bz_m), W'(eb));
    chk("busy_lsb", W'(bz_l), W'(eb));
    chk("ovr_msb", W'(ov_m), W'(e_o));
    chk("ovr_lsb", W'(ov_l), W'(e_o));
  endtask
  task automatic send(input logic [W-1:0] w, input logic s, input logic y);
    for (int i = W - 1; i >= 0; i--) cyc(1, s && i == W - 1, 1, w[i], y, 0);
  endtask
  initial begin
    logic [W-1:0] ser;
    cyc(0, 1, 1, 1, 1, 1);
    cyc(0, 0, 1, 0, 1, 0);
    chk("reset_pout", po_m, 4'h0);
    cyc(1, 0, 1, 1, 0, 0);
    cyc(1, 0, 1, 0, 0, 0);
    chk("idle_busy", W'(bz_m), 4'h0);
    send(4'hB, 1, 0);
    chk("basic_msb", po_m, 4'hB);
    chk("basic_lsb", po_l, 4'hD);
    chk("basic_valid", W'(vo_m), 4'h1);
    cyc(1, 0, 0, 0, 1, 0);
    chk("accept_valid", W'(vo_m), 4'h0);
    ser = 4'h6;
    for (int i = 0; i < W; i++) begin
      cyc(1, i == 0, 1, ser[W-1], 0, 0);
      ser = ser << 1;
    end
    chk("loopback", po_m, 4'h6);
    cyc(1, 0, 0, 0, 1, 0);
    send(4'h3, 0, 0);
    send(4'hC, 0, 0);
    chk("ovr_word", po_m, 4'hC);
    chk("ovr_flag", W'(ov_m), 4'h1);
    cyc(1, 0, 0, 0, 0, 1);
    chk("ovr_clear", W'(ov_m), 4'h0);
    cyc(1, 0, 0, 0, 1, 0);
    chk("ovr_accept", W'(vo_m), 4'h0);
    cyc(1, 0, 1, 1, 0, 0);
    cyc(1, 0, 1, 1, 0, 0);
    send(4'h5, 1, 0);
    chk("realign", po_m, 4'h5);
    cyc(1, 0, 0, 0, 1, 0);
    cyc(1, 0, 1, 1, 0, 0);
    cyc(1, 0, 1, 0, 0, 0);
    cyc(1, 0, 1, 1, 0, 0);
    cyc(1, 1, 1, 1, 0, 0);
    chk("start_wins_valid", W'(vo_m), 4'h0);
    chk("start_wins_busy", W'(bz_m), 4'h1);
    cyc(1, 0, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0);
    cyc(1, 0, 1, 1, 0, 0);
    chk("start_wins_word", po_m, 4'h9);
    cyc(1, 0, 0, 0, 1, 0);
    for (int i = W - 1; i >= 0; i--) begin
      cyc(1, i == W - 1, 1, ser_bit(4'hA, i), 0, 0);
      cyc(1, 0, 0, 1, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
    end
    chk("gaps", po_m, 4'hA);
    cyc(1, 1, 1, 1, 0, 0);
    cyc(1, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 0);
    chk("rst_mid_busy", W'(bz_m), 4'h0);
    chk("rst_mid_valid", W'(vo_m), 4'h0);
    send(4'h9, 1, 0);
    chk("after_reset", po_m, 4'h9);
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(49) != 0, $urandom_range(7) == 0, $urandom_range(1) == 1,
          $urandom_range(1) == 1, $urandom_range(2) == 0, $urandom_range(9) == 0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
  function automatic logic ser_bit(input logic [W-1:0] w, input int i);
    return w[i];
  endfunction
endmodule
